// File: rtl/my_axi4_lite_mst_bridge_if.sv
// AXI4-Lite channel bundle (AW, W, B, AR, R) with master and slave views.
interface aix4_lite_if #(
  parameter int unsigned ADDR_BIT_WIDTH = 4,
  parameter int unsigned DATA_BIT_WIDTH = 32
);
  localparam int unsigned STRB_BIT_WIDTH = DATA_BIT_WIDTH / 8;

  logic                      awvalid;
  logic                      awready;
  logic [ADDR_BIT_WIDTH-1:0] awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_BIT_WIDTH-1:0] wdata;
  logic [STRB_BIT_WIDTH-1:0] wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_BIT_WIDTH-1:0] araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_BIT_WIDTH-1:0] rdata;
  logic [1:0]                rresp;

  modport mst_port (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slv_port (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/my_axi4_lite_mst_bridge.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out,
// one response back on a valid/ready port.
module my_axi4_lite_mst_bridge #(
  parameter int unsigned ADDR_BIT_WIDTH = 4,
  parameter int unsigned DATA_BIT_WIDTH = 32
) (
  input  logic                        i_clk,
  input  logic                        i_async_rst_n,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_wr,
  input  logic [ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic                        o_rsp_wr,
  output logic [DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                  o_rsp_resp,
  output logic                        o_busy,
  aix4_lite_if.mst_port               if_m_axi4_lite
);

  localparam int unsigned STRB_BIT_WIDTH = DATA_BIT_WIDTH / 8;

  if ($bits(if_m_axi4_lite.awaddr) != ADDR_BIT_WIDTH) begin : g_addr_width_chk
    $error("ADDR_BIT_WIDTH does not match the AXI4-Lite interface");
  end
  if ($bits(if_m_axi4_lite.wdata) != DATA_BIT_WIDTH) begin : g_data_width_chk
    $error("DATA_BIT_WIDTH does not match the AXI4-Lite interface");
  end
  if (DATA_BIT_WIDTH != 32 && DATA_BIT_WIDTH != 64) begin : g_data_value_chk
    $error("DATA_BIT_WIDTH must be 32 or 64");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_AW_W,
    ST_WR_B,
    ST_RD_AR,
    ST_RD_R,
    ST_RSP
  } state_e;

  state_e                    state_q;
  logic                      cmd_ready_q;
  logic                      busy_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      bready_q;
  logic                      arvalid_q;
  logic                      rready_q;
  logic [ADDR_BIT_WIDTH-1:0] awaddr_q;
  logic [ADDR_BIT_WIDTH-1:0] araddr_q;
  logic [DATA_BIT_WIDTH-1:0] wdata_q;
  logic [STRB_BIT_WIDTH-1:0] wstrb_q;
  logic                      rsp_valid_q;
  logic                      rsp_wr_q;
  logic [DATA_BIT_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]                rsp_resp_q;

  // AW and W retire independently; a channel counts as done once its valid is low
  // or it handshakes this cycle.
  logic aw_done_c;
  logic w_done_c;
  assign aw_done_c = !awvalid_q || if_m_axi4_lite.awready;
  assign w_done_c  = !wvalid_q  || if_m_axi4_lite.wready;

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (i_cmd_wr) begin
              awaddr_q  <= i_cmd_addr;
              wdata_q   <= i_cmd_wdata;
              wstrb_q   <= i_cmd_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR_AW_W;
            end else begin
              araddr_q  <= i_cmd_addr;
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_AR;
            end
          end
        end
        ST_WR_AW_W: begin
          if (awvalid_q && if_m_axi4_lite.awready) awvalid_q <= 1'b0;
          if (wvalid_q && if_m_axi4_lite.wready)   wvalid_q  <= 1'b0;
          if (aw_done_c && w_done_c) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (if_m_axi4_lite.bvalid) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_wr_q    <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= if_m_axi4_lite.bresp;
            state_q     <= ST_RSP;
          end
        end
        ST_RD_AR: begin
          if (if_m_axi4_lite.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_R;
          end
        end
        ST_RD_R: begin
          if (if_m_axi4_lite.rvalid) begin
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= if_m_axi4_lite.rdata;
            rsp_resp_q  <= if_m_axi4_lite.rresp;
            state_q     <= ST_RSP;
          end
        end
        ST_RSP: begin
          // Ready is raised only on the way back to IDLE, so no command can slip in here.
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_busy      = busy_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_wr    = rsp_wr_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_resp  = rsp_resp_q;

  assign if_m_axi4_lite.awvalid = awvalid_q;
  assign if_m_axi4_lite.awaddr  = awaddr_q;
  assign if_m_axi4_lite.awprot  = 3'b000;
  assign if_m_axi4_lite.wvalid  = wvalid_q;
  assign if_m_axi4_lite.wdata   = wdata_q;
  assign if_m_axi4_lite.wstrb   = wstrb_q;
  assign if_m_axi4_lite.bready  = bready_q;
  assign if_m_axi4_lite.arvalid = arvalid_q;
  assign if_m_axi4_lite.araddr  = araddr_q;
  assign if_m_axi4_lite.arprot  = 3'b000;
  assign if_m_axi4_lite.rready  = rready_q;

endmodule

// File: tb/tb_my_axi4_lite_mst_bridge.sv
// Directed bench for the AXI4-Lite master bridge against a 4-register slave model
// with adjustable ready latency, always-ready mode and an error-read mode.
module tb_my_axi4_lite_mst_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_wr, rsp_ready;
  logic [3:0]  cmd_addr, cmd_wstrb;
  logic [31:0] cmd_wdata;
  logic        cmd_ready, rsp_valid, rsp_wr, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  int n_tests = 0;
  int n_fail  = 0;

  aix4_lite_if #(.ADDR_BIT_WIDTH(4), .DATA_BIT_WIDTH(32)) axi ();

  my_axi4_lite_mst_bridge #(.ADDR_BIT_WIDTH(4), .DATA_BIT_WIDTH(32)) dut (
    .i_clk(clk), .i_async_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_wr(cmd_wr),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_wr(rsp_wr),
    .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_busy(busy),
    .if_m_axi4_lite(axi)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int          aw_lat = 0, w_lat = 0;
  bit          ready_hi = 1'b0, err_rd = 1'b0;
  int          cyc = 0;
  logic [31:0] regs [4];
  logic        awready_r, wready_r, arready_r, bvalid_r, rvalid_r;
  logic [31:0] rdata_r;
  logic [1:0]  rresp_r;
  logic        aw_got, w_got;
  logic [3:0]  aw_addr_l, w_strb_l;
  logic [31:0] w_data_l;
  int          aw_cnt, w_cnt;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0;

  assign axi.awready = ready_hi ? 1'b1 : awready_r;
  assign axi.wready  = ready_hi ? 1'b1 : wready_r;
  assign axi.arready = ready_hi ? 1'b1 : arready_r;
  assign axi.bvalid  = bvalid_r;
  assign axi.bresp   = 2'b00;
  assign axi.rvalid  = rvalid_r;
  assign axi.rdata   = rdata_r;
  assign axi.rresp   = rresp_r;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready_r <= 1'b0; wready_r <= 1'b0; arready_r <= 1'b0;
      bvalid_r <= 1'b0; rvalid_r <= 1'b0; rdata_r <= '0; rresp_r <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_addr_l <= '0; w_strb_l <= '0; w_data_l <= '0;
      aw_cnt <= 0; w_cnt <= 0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (axi.awvalid && axi.awready) begin
        aw_hs <= aw_hs + 1; aw_hs_cyc <= cyc;
        aw_got <= 1'b1; aw_addr_l <= axi.awaddr; awready_r <= 1'b0; aw_cnt <= 0;
      end else if (axi.awvalid && !awready_r && !aw_got) begin
        if (aw_cnt >= aw_lat) awready_r <= 1'b1;
        else aw_cnt <= aw_cnt + 1;
      end
      if (axi.wvalid && axi.wready) begin
        w_hs <= w_hs + 1; w_hs_cyc <= cyc;
        w_got <= 1'b1; w_data_l <= axi.wdata; w_strb_l <= axi.wstrb; wready_r <= 1'b0; w_cnt <= 0;
      end else if (axi.wvalid && !wready_r && !w_got) begin
        if (w_cnt >= w_lat) wready_r <= 1'b1;
        else w_cnt <= w_cnt + 1;
      end
      if (aw_got && w_got && !bvalid_r) begin
        for (int b = 0; b < 4; b++)
          if (w_strb_l[b]) regs[aw_addr_l[3:2]][8*b +: 8] <= w_data_l[8*b +: 8];
        bvalid_r <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (bvalid_r && axi.bready) begin
        bvalid_r <= 1'b0; b_hs <= b_hs + 1;
      end
      if (axi.arvalid && axi.arready) begin
        ar_hs <= ar_hs + 1; arready_r <= 1'b0; rvalid_r <= 1'b1;
        rdata_r <= err_rd ? 32'h1234_5678 : regs[axi.araddr[3:2]];
        rresp_r <= err_rd ? 2'b10 : 2'b00;
      end else if (axi.arvalid && !arready_r) begin
        arready_r <= 1'b1;
      end
      if (rvalid_r && axi.rready) rvalid_r <= 1'b0;
    end
  end

  // Protocol monitor: a pending valid must stay high with a stable payload.
  int          viol = 0;
  logic        awv_p, awr_p, wv_p, wr_p, arv_p, arr_p;
  logic [3:0]  awa_p, ara_p;
  logic [31:0] wd_p;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awv_p <= 1'b0; awr_p <= 1'b0; wv_p <= 1'b0; wr_p <= 1'b0; arv_p <= 1'b0; arr_p <= 1'b0;
      awa_p <= '0; ara_p <= '0; wd_p <= '0;
    end else begin
      if (awv_p && !awr_p && (!axi.awvalid || axi.awaddr != awa_p)) viol <= viol + 1;
      if (wv_p  && !wr_p  && (!axi.wvalid  || axi.wdata  != wd_p))  viol <= viol + 1;
      if (arv_p && !arr_p && (!axi.arvalid || axi.araddr != ara_p)) viol <= viol + 1;
      awv_p <= axi.awvalid; awr_p <= axi.awready; awa_p <= axi.awaddr;
      wv_p  <= axi.wvalid;  wr_p  <= axi.wready;  wd_p  <= axi.wdata;
      arv_p <= axi.arvalid; arr_p <= axi.arready; ara_p <= axi.araddr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                          input logic [3:0] st);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
    for (int n = 0; n < 100 && !cmd_ready; n++) @(negedge clk);
    if (!cmd_ready) check_eq("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input bit ack, output int lat, output logic wr,
                          output logic [31:0] rd, output logic [1:0] rs);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 200);
    if (!rsp_valid) check_eq("rsp_timeout", 64'(rsp_valid), 64'd1);
    wr = rsp_wr; rd = rsp_rdata; rs = rsp_resp;
    if (ack) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  int          lat, stable, b0, aw0, w0;
  logic        r_wr;
  logic [31:0] r_rd;
  logic [1:0]  r_rs;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0;
    #12;
    check_eq("rst_awvalid", 64'(axi.awvalid), 64'd0);
    check_eq("rst_arvalid", 64'(axi.arvalid), 64'd0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("rst_busy", 64'(busy), 64'd0);

    // 1: zero-wait always-ready slave, minimum latency
    ready_hi = 1'b1;
    send_cmd(1'b1, 4'h4, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(1'b1, lat, r_wr, r_rd, r_rs);
    check_eq("t1_wr_lat", 64'(lat), 64'd4);
    check_eq("t1_wr_flag", 64'(r_wr), 64'd1);
    check_eq("t1_wr_resp", 64'(r_rs), 64'd0);
    check_eq("t1_wr_rdata", 64'(r_rd), 64'd0);
    send_cmd(1'b0, 4'h4, 32'h0, 4'h0);
    wait_rsp(1'b1, lat, r_wr, r_rd, r_rs);
    check_eq("t1_rd_lat", 64'(lat), 64'd3);
    check_eq("t1_rd_flag", 64'(r_wr), 64'd0);
    check_eq("t1_rd_data", 64'(r_rd), 64'hDEAD_BEEF);
    check_eq("t1_rd_resp", 64'(r_rs), 64'd0);

    // 2: byte strobes on a ready-after-valid slave
    ready_hi = 1'b0;
    send_cmd(1'b1, 4'h8, 32'hFFFF_FFFF, 4'hF);
    wait_rsp(1'b1, lat, r_wr, r_rd, r_rs);
    send_cmd(1'b1, 4'h8, 32'h0000_0000, 4'h5);
    wait_rsp(1'b1, lat, r_wr, r_rd, r_rs);
    send_cmd(1'b0, 4'h8, 32'h0, 4'h0);
    wait_rsp(1'b1, lat, r_wr, r_rd, r_rs);
    check_eq("t2_strb_data", 64'(r_rd), 64'hFF00_FF00);

    // 3: response back-pressure
    send_cmd(1'b0, 4'h4, 32'h0, 4'h0);
    wait_rsp(1'b0, lat, r_wr, r_rd, r_rs);
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_rdata == 32'hDEAD_BEEF && !rsp_wr && rsp_resp == 2'b00 &&
          !cmd_ready && busy) stable++;
    end
    check_eq("t3_hold_cycles", 64'(stable), 64'd10);
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    check_eq("t3_rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check_eq("t3_cmd_ready_back", 64'(cmd_ready), 64'd1);
    check_eq("t3_busy_clear", 64'(busy), 64'd0);

    // 4: AWREADY three cycles behind WREADY
    aw_lat = 3; w_lat = 0;
    b0 = b_hs; aw0 = aw_hs; w0 = w_hs;
    send_cmd(1'b1, 4'hC, 32'hA5A5_5A5A, 4'hF);
    wait_rsp(1'b1, lat, r_wr, r_rd, r_rs);
    check_eq("t4_aw_after_w", 64'(aw_hs_cyc - w_hs_cyc), 64'd3);
    check_eq("t4_b_count", 64'(b_hs - b0), 64'd1);
    check_eq("t4_aw_count", 64'(aw_hs - aw0), 64'd1);
    check_eq("t4_w_count", 64'(w_hs - w0), 64'd1);
    aw_lat = 0;
    send_cmd(1'b0, 4'hC, 32'h0, 4'h0);
    wait_rsp(1'b1, lat, r_wr, r_rd, r_rs);
    check_eq("t4_readback", 64'(r_rd), 64'hA5A5_5A5A);

    // 5: SLVERR read is passed through
    err_rd = 1'b1;
    send_cmd(1'b0, 4'h0, 32'h0, 4'h0);
    wait_rsp(1'b1, lat, r_wr, r_rd, r_rs);
    check_eq("t5_resp", 64'(r_rs), 64'h2);
    check_eq("t5_rdata", 64'(r_rd), 64'h1234_5678);
    err_rd = 1'b0;
    check_eq("valid_stability_violations", 64'(viol), 64'd0);

    // 6: asynchronous reset while AW and W are both pending
    aw_lat = 20; w_lat = 20;
    send_cmd(1'b1, 4'h4, 32'h1111_2222, 4'hF);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_eq("t6_pre_awvalid", 64'(axi.awvalid), 64'd1);
    check_eq("t6_pre_wvalid", 64'(axi.wvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_awvalid", 64'(axi.awvalid), 64'd0);
    check_eq("t6_wvalid", 64'(axi.wvalid), 64'd0);
    check_eq("t6_bready", 64'(axi.bready), 64'd0);
    check_eq("t6_busy", 64'(busy), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    aw_lat = 0; w_lat = 0;
    send_cmd(1'b0, 4'h4, 32'h0, 4'h0);
    wait_rsp(1'b1, lat, r_wr, r_rd, r_rs);
    check_eq("t6_read_after_reset", 64'(r_rd), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
